// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package cdb_pkg;

  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

  typedef enum logic {
    GNT_ADD = 1'b0,
    GNT_MUL = 1'b1
  } grant_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU result FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-FU common-data-bus arbiter: round-robin by default, fixed mul priority
// when CDB_MUL_PRIORITY_EN is defined.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     add_valid,
  input  logic [TAG_W-1:0]         add_tag,
  input  logic [DATA_W-1:0]        add_data,
  output logic                     add_ready,
  input  logic                     mul_valid,
  input  logic [TAG_W-1:0]         mul_tag,
  input  logic [DATA_W-1:0]        mul_data,
  output logic                     mul_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [$clog2(DEPTH):0]   add_count,
  output logic [$clog2(DEPTH):0]   mul_count
);

  localparam int EW = TAG_W + DATA_W;

  logic [EW-1:0] add_head;
  logic [EW-1:0] mul_head;
  logic          add_full;
  logic          add_empty;
  logic          mul_full;
  logic          mul_empty;
  logic          add_push;
  logic          mul_push;
  logic          add_pop;
  logic          mul_pop;
  logic          grant_any;
  grant_e        grant;
  grant_e        last_grant;

  // Ready ignores any same-cycle pop so a full FIFO never accepts.
  assign add_ready = !add_full && !reset;
  assign mul_ready = !mul_full && !reset;
  assign add_push  = add_valid && add_ready;
  assign mul_push  = mul_valid && mul_ready;

  cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_add_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (add_push),
    .push_data ({add_tag, add_data}),
    .pop       (add_pop),
    .head      (add_head),
    .full      (add_full),
    .empty     (add_empty),
    .count     (add_count)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_mul_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (mul_push),
    .push_data ({mul_tag, mul_data}),
    .pop       (mul_pop),
    .head      (mul_head),
    .full      (mul_full),
    .empty     (mul_empty),
    .count     (mul_count)
  );

  always_comb begin
    grant_any = !add_empty || !mul_empty;
    grant     = GNT_ADD;
`ifdef CDB_MUL_PRIORITY_EN
    if (!mul_empty) grant = GNT_MUL;
`else
    if (!add_empty && !mul_empty) begin
      grant = (last_grant == GNT_MUL) ? GNT_ADD : GNT_MUL;
    end else if (add_empty) begin
      grant = GNT_MUL;
    end
`endif
    add_pop = grant_any && (grant == GNT_ADD) && !reset;
    mul_pop = grant_any && (grant == GNT_MUL) && !reset;
  end

  // The bus keeps its last tag/data on idle cycles; only cdb_valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      last_grant <= GNT_MUL;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        last_grant <= grant;
        {cdb_tag, cdb_data} <= (grant == GNT_ADD) ? add_head : mul_head;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed scenarios.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int DEPTH  = 2;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              add_valid, mul_valid;
  logic [TAG_W-1:0]  add_tag, mul_tag;
  logic [DATA_W-1:0] add_data, mul_data;
  logic              add_ready, mul_ready;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [CW-1:0]     add_count, mul_count;

  int checks   = 0;
  int failures = 0;

  cdb_entry_t  addQ[$];
  cdb_entry_t  mulQ[$];
  grant_e      lastGrant;
  logic        expValid;
  logic [3:0]  expTag;
  logic [31:0] expData;
  bit          primed = 0;
  bit          accMul;

  int          addBc, mulBc, prevFu, altBad;
  logic [3:0]  mulSeen[$];

  cdb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .add_valid (add_valid),
    .add_tag   (add_tag),
    .add_data  (add_data),
    .add_ready (add_ready),
    .mul_valid (mul_valid),
    .mul_tag   (mul_tag),
    .mul_data  (mul_data),
    .mul_ready (mul_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .add_count (add_count),
    .mul_count (mul_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compares every DUT output against the reference model's current view.
  task automatic checkOutput();
    if (primed) begin
      check("add_ready", 32'(!reset && addQ.size() < DEPTH), 32'(add_ready));
      check("mul_ready", 32'(!reset && mulQ.size() < DEPTH), 32'(mul_ready));
      check("add_count", 32'(add_count), 32'(addQ.size()));
      check("mul_count", 32'(mul_count), 32'(mulQ.size()));
      check("cdb_valid", 32'(cdb_valid), 32'(expValid));
      check("cdb_tag", 32'(cdb_tag), 32'(expTag));
      check("cdb_data", cdb_data, expData);
    end
  endtask

  // Advances the model by one rising edge using the inputs currently driven.
  task automatic modelStep();
    bit ra, rm, hasA, hasM;
    grant_e g;
    cdb_entry_t e;
    accMul = 0;
    if (reset) begin
      addQ.delete();
      mulQ.delete();
      expValid  = 0;
      expTag    = '0;
      expData   = '0;
      lastGrant = GNT_MUL;
      primed    = 1;
      return;
    end
    ra   = addQ.size() < DEPTH;
    rm   = mulQ.size() < DEPTH;
    hasA = addQ.size() > 0;
    hasM = mulQ.size() > 0;
`ifdef CDB_MUL_PRIORITY_EN
    g = hasM ? GNT_MUL : GNT_ADD;
`else
    if (hasA && hasM) g = (lastGrant == GNT_MUL) ? GNT_ADD : GNT_MUL;
    else              g = hasA ? GNT_ADD : GNT_MUL;
`endif
    if (hasA || hasM) begin
      e         = (g == GNT_ADD) ? addQ.pop_front() : mulQ.pop_front();
      expValid  = 1;
      expTag    = e.tag;
      expData   = e.data;
      lastGrant = g;
    end else begin
      expValid = 0;
    end
    if (add_valid && ra) addQ.push_back('{tag: add_tag, data: add_data});
    if (mul_valid && rm) begin
      mulQ.push_back('{tag: mul_tag, data: mul_data});
      accMul = 1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic av, input logic [3:0] at,
                               input logic [31:0] ad, input logic mv,
                               input logic [3:0] mt, input logic [31:0] md);
    reset = r; add_valid = av; add_tag = at; add_data = ad;
    mul_valid = mv; mul_tag = mt; mul_data = md;
    #1;
    checkOutput();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
  endtask

  // Tallies broadcasts: add tags are 8..15, mul tags 0..7 in the directed tests.
  task automatic tally();
    int fu;
    if (cdb_valid === 1'b1) begin
      fu = cdb_tag[3] ? 0 : 1;
      if (fu == 0) addBc++; else begin mulBc++; mulSeen.push_back(cdb_tag); end
      if (fu == prevFu) altBad++;
      prevFu = fu;
    end
  endtask

  task automatic clearTally();
    addBc = 0; mulBc = 0; prevFu = -1; altBad = 0;
    mulSeen.delete();
  endtask

  initial begin
    int mi;
    reset = 1; add_valid = 0; mul_valid = 0;
    add_tag = '0; mul_tag = '0; add_data = '0; mul_data = '0;
    @(negedge clk);

    // Single add result, two-edge latency.
    idle(1);
    check("rst_add_ready", 32'(add_ready), 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("rst_add_count", 32'(add_count), 32'd0);
    applyStimulus(0, 1, 4'd3, 32'h11, 0, 4'd0, 32'h0);
    check("single_count", 32'(add_count), 32'd1);
    check("single_early", 32'(cdb_valid), 32'd0);
    idle(0);
    check("single_valid", 32'(cdb_valid), 32'd1);
    check("single_tag", 32'(cdb_tag), 32'd3);
    check("single_data", cdb_data, 32'h11);
    idle(0);
    check("single_drop", 32'(cdb_valid), 32'd0);
    check("single_hold", 32'(cdb_tag), 32'd3);

    // Tie on the same edge right after reset.
    idle(1);
    applyStimulus(0, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB);
    idle(0);
`ifdef CDB_MUL_PRIORITY_EN
    check("tie_first_tag", 32'(cdb_tag), 32'd2);
    idle(0);
    check("tie_second_tag", 32'(cdb_tag), 32'd1);
`else
    check("tie_first_tag", 32'(cdb_tag), 32'd1);
    check("tie_first_data", cdb_data, 32'hA);
    idle(0);
    check("tie_second_tag", 32'(cdb_tag), 32'd2);
    check("tie_second_data", cdb_data, 32'hB);
`endif
    check("tie_second_valid", 32'(cdb_valid), 32'd1);

`ifndef CDB_MUL_PRIORITY_EN
    // Back-pressure: mul offers tags 5,6,7 while add is always valid.
    idle(1);
    clearTally();
    applyStimulus(0, 1, 4'd8, 32'h80, 1, 4'd5, 32'h50); tally();
    applyStimulus(0, 1, 4'd9, 32'h81, 1, 4'd6, 32'h60); tally();
    check("bp_mul_count", 32'(mul_count), 32'd2);
    check("bp_mul_ready", 32'(mul_ready), 32'd0);
    mi = 2;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 4'(8 + (i % 8)), 32'(i), mi < 3, 4'(5 + mi), 32'(mi));
      if (accMul) mi++;
      tally();
    end
    for (int i = 0; i < 8; i++) begin idle(0); tally(); end
    check("bp_mul_n", 32'(mulSeen.size()), 32'd3);
    for (int i = 0; i < 3 && i < mulSeen.size(); i++)
      check("bp_mul_order", 32'(mulSeen[i]), 32'(5 + i));

    // Fairness with both FUs valid for 20 cycles.
    idle(1);
    clearTally();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 4'(8 | (i % 8)), $urandom, 1, 4'(i % 8), $urandom);
      tally();
    end
    check("fair_total", 32'(addBc + mulBc), 32'd19);
    check("fair_add", 32'(addBc >= 9 && addBc <= 11), 32'd1);
    check("fair_mul", 32'(mulBc >= 9 && mulBc <= 11), 32'd1);
    check("fair_alternate", 32'(altBad), 32'd0);
`else
    // Fixed priority: mul monopolises the bus while it keeps requesting.
    idle(1);
    clearTally();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 4'(8 | (i % 8)), $urandom, 1, 4'(i % 8), $urandom);
      tally();
    end
    check("prio_add_none", 32'(addBc), 32'd0);
    check("prio_mul_all", 32'(mulBc), 32'd11);
    for (int i = 0; i < 6; i++) begin idle(0); tally(); end
    check("prio_add_after_drain", 32'(addBc >= 1), 32'd1);
`endif

    // Reset while both FIFOs hold entries.
    idle(1);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 4'(8 + i), 32'(i), 1, 4'(i), 32'(i));
`ifndef CDB_MUL_PRIORITY_EN
    check("mid_add_count", 32'(add_count), 32'd2);
    check("mid_mul_count", 32'(mul_count), 32'd1);
`endif
    applyStimulus(1, 1, 4'hF, 32'hDEAD, 1, 4'h7, 32'hBEEF);
    check("mid_rst_add_count", 32'(add_count), 32'd0);
    check("mid_rst_mul_count", 32'(mul_count), 32'd0);
    check("mid_rst_valid", 32'(cdb_valid), 32'd0);
    check("mid_rst_tag", 32'(cdb_tag), 32'd0);
    clearTally();
    for (int i = 0; i < 4; i++) begin idle(0); tally(); end
    check("mid_no_stale", 32'(addBc + mulBc), 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                    4'($urandom), $urandom, ($urandom_range(0, 3) != 0),
                    4'($urandom), $urandom);
    end
    idle(0);
    #1;
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, per-FU result FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, reservation-station tag width.
REQ-003 SHALL have parameter DATA_W, default 32, result data width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports add_valid input 1, add_tag input TAG_W, add_data input DATA_W: adder FU result offer.
REQ-007 SHALL have port add_ready  output  1  adder FIFO can accept.
REQ-008 SHALL have ports mul_valid input 1, mul_tag input TAG_W, mul_data input DATA_W: multiplier FU result offer.
REQ-009 SHALL have port mul_ready  output  1  multiplier FIFO can accept.
REQ-010 SHALL have ports cdb_valid output 1, cdb_tag output TAG_W, cdb_data output DATA_W: single common-data-bus broadcast.
REQ-011 SHALL have ports add_count, mul_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-012 SHALL accept a result when X_valid && X_ready at a rising edge, pushing {tag,data} into that FU's FIFO.
REQ-013 SHALL drive X_ready = !full, independent of a same-cycle pop; a full FIFO never accepts, even while popping.
REQ-014 SHALL, each cycle, select at most one non-empty FIFO, pop its head, and register it onto cdb_* at the next edge.
REQ-015 SHALL assert cdb_valid for exactly one cycle per broadcast entry; cdb_tag/cdb_data hold last values when cdb_valid=0.
REQ-016 SHALL broadcast a result accepted at edge k into an empty FIFO, with no competing request, in the cycle after edge k+1 (2-edge latency).
REQ-017 SHALL arbitrate round-robin: if both FIFOs are non-empty, grant the FU not granted most recently; a single non-empty FIFO is always granted.
REQ-018 SHALL update the last-grant pointer only on an actual grant; idle cycles leave it unchanged.
REQ-019 SHALL preserve per-FU FIFO order; no entry dropped or duplicated.
REQ-020 SHALL, on simultaneous push and pop of the same FIFO, leave occupancy unchanged and handle pointer wrap-around at DEPTH.
REQ-021 SHALL bound starvation: with both FUs continuously requesting, each broadcasts at least once every 2 cycles.
REQ-022 SHALL keep add_count/mul_count exact, in range 0..DEPTH.

Reset
REQ-023 SHALL, when reset=1 at a rising edge, empty both FIFOs, set cdb_valid=0, cdb_tag=0, cdb_data=0, and last-grant pointer = mul (so add wins the first tie).
REQ-024 SHALL drive add_ready=mul_ready=0 while reset is asserted and 1 the cycle after it deasserts.
REQ-025 SHALL discard in-flight entries when reset is asserted mid-operation; no broadcast after the reset edge.

Configuration
REQ-026 SHALL, when macro CDB_MUL_PRIORITY_EN is defined, replace round-robin with fixed priority: mul always wins ties; the REQ-021 bound then applies only to mul.
REQ-027 SHALL, when CDB_MUL_PRIORITY_EN is undefined, implement round-robin per REQ-017.

Structure
REQ-028 SHALL place the cdb_entry_t struct {tag, data}, the default TAG_W/DATA_W constants and the grant enum {GNT_ADD, GNT_MUL} in shared package cdb_pkg.
REQ-029 SHALL instantiate sub-module cdb_fifo (parameterised DEPTH, push/pop/full/empty/count) once per FU.

Verification
REQ-030 SHALL test single add: add tag=3,data=0x11 after reset -> cdb_valid one cycle with tag 3, data 0x11 after 2 edges.
REQ-031 SHALL test tie: add{1,0xA} and mul{2,0xB} same edge -> add broadcast first, mul next cycle.
REQ-032 SHALL test back-pressure: DEPTH=2, mul pushes 3 back-to-back while add saturates -> mul_ready=0 when mul_count=2, all 3 mul tags broadcast in order.
REQ-033 SHALL test fairness: both FUs valid for 20 cycles -> cdb alternates add/mul, 10 grants each ±1.
REQ-034 SHALL test reset mid-operation: both FIFOs full, reset one cycle -> counts 0, cdb_valid=0, no stale tag broadcast.
REQ-035 SHALL test CDB_MUL_PRIORITY_EN: both FUs continuously valid -> only mul broadcast until mul FIFO drains.
